seq_divider_16_16_16: RTL and testbench

Sequential signed fixed-point divider producing OUT = A / B in the 16-bit 1_2_13 format (sign, 2 integer bits, 13 fraction bits). It is the inverse companion of the multiplier_x_y_z units and serves normalisation and gate-scaling paths that need a quotient. It uses restoring division at one quotient bit per cycle, truncates toward zero, saturates like the adder/subtracter family, and connects through a valid/ready handshake on both sides.

---
 rtl/seq_divider_16_16_16.sv | 158 +++++++++++++++
 tb/tb_seq_divider_16_16_16.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16_16_16.sv
// Signed 1_2_13 restoring divider, one quotient bit per cycle, truncating toward zero
// with saturation and divide-by-zero clamping, valid/ready on both sides.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready high
// CALC  | one restoring step per edge, W+N_FRAC steps on a down-counter
// FIX   | sign correction, saturation and div0 clamp into output regs
// DONE  | out_valid high, result held until out_ready
module seq_divider_16_16_16 #(
  parameter int W      = 16,
  parameter int N_FRAC = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         sat,
  output logic         div0
);

  localparam int QW = W + N_FRAC;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] ITER    = CW'(QW);
  localparam logic [QW-1:0] POS_MAX = QW'((1 << (W - 1)) - 1);
  localparam logic [QW-1:0] NEG_MAX = QW'(1 << (W - 1));
  localparam logic [W-1:0]  OUT_MAX = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]  OUT_MIN = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic          sign_q;
  logic          asign_q;
  logic          div0_q;
  logic [W-1:0]  mag_b_q;
  logic [QW-1:0] dividend_q;
  logic [W:0]    remainder_q;
  logic [QW-1:0] quotient_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  mag_a;
  logic [W+1:0]  rem_sh;
  logic [W+1:0]  trial;
  logic          ge;
  logic [W-1:0]  fix_out;
  logic          fix_sat;

  // |0x8000| stays representable because magnitudes are held unsigned.
  assign mag_a  = a[W-1] ? (~a + 1'b1) : a;
  assign rem_sh = {remainder_q, dividend_q[QW-1]};
  assign trial  = rem_sh - {2'b00, mag_b_q};
  assign ge     = ~trial[W+1];

  always_comb begin
    fix_out = '0;
    fix_sat = 1'b0;
    if (div0_q) begin
      fix_out = asign_q ? OUT_MIN : OUT_MAX;
      fix_sat = 1'b1;
    end else if (!sign_q) begin
      if (quotient_q > POS_MAX) begin
        fix_out = OUT_MAX;
        fix_sat = 1'b1;
      end else begin
        fix_out = quotient_q[W-1:0];
      end
    end else begin
      if (quotient_q > NEG_MAX) begin
        fix_out = OUT_MIN;
        fix_sat = 1'b1;
      end else begin
        fix_out = ~quotient_q[W-1:0] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      asign_q     <= 1'b0;
      div0_q      <= 1'b0;
      mag_b_q     <= '0;
      dividend_q  <= '0;
      remainder_q <= '0;
      quotient_q  <= '0;
      cnt_q       <= '0;
      out         <= '0;
      sat         <= 1'b0;
      div0        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q      <= a[W-1] ^ b[W-1];
            asign_q     <= a[W-1];
            div0_q      <= (b == '0);
            mag_b_q     <= b[W-1] ? (~b + 1'b1) : b;
            dividend_q  <= {mag_a, {N_FRAC{1'b0}}};
            remainder_q <= '0;
            quotient_q  <= '0;
            cnt_q       <= ITER;
          end
        end
        CALC: begin
          remainder_q <= ge ? trial[W:0] : rem_sh[W:0];
          quotient_q  <= {quotient_q[QW-2:0], ge};
          dividend_q  <= {dividend_q[QW-2:0], 1'b0};
          cnt_q       <= cnt_q - 1'b1;
        end
        FIX: begin
          out  <= fix_out;
          sat  <= fix_sat;
          div0 <= div0_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16_16_16.sv
// Self-checking bench for seq_divider_16_16_16: directed table, backpressure,
// mid-calculation reset and randomized operands against an arithmetic model.
module tb_seq_divider_16_16_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        sat;
  logic        div0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        s;
    logic        d;
  } vec_t;

  vec_t vecs [13];

  seq_divider_16_16_16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .sat      (sat),
    .div0     (div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Quotient from plain signed arithmetic: a*2^13/b truncates toward zero, then clamp.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                output logic [15:0] o, output logic s, output logic d);
    longint sa, sb, q;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (sb == 0) begin
      d = 1'b1;
      s = 1'b1;
      o = (sa < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
      d = 1'b0;
      q = (sa * 8192) / sb;
      if (q > 32767) begin
        o = 16'h7FFF; s = 1'b1;
      end else if (q < -32768) begin
        o = 16'h8000; s = 1'b1;
      end else begin
        o = q[15:0]; s = 1'b0;
      end
    end
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic [15:0] eo,
                        input logic es, input logic ed, input int hold, input bit pulse);
    int lat;
    bit rdy_bad;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta;
    b = tbv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 0;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) rdy_bad = 1'b1;
    end
    chk("latency", 32'(lat), 32'd30);
    chk("in_ready_busy", 32'(rdy_bad), 32'd0);
    chk("out", 32'(out), 32'(eo));
    chk("sat", 32'(sat), 32'(es));
    chk("div0", 32'(div0), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (pulse) begin
        in_valid = ~in_valid;
        a = 16'h1234;
        b = 16'h0100;
      end
      @(posedge clk);
      #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out", 32'(out), 32'(eo));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("out_kept", 32'(out), 32'(eo));
  endtask

  initial begin
    logic [15:0] ra, rb, mo;
    logic        ms, md;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;

    vecs[0]  = '{16'h2000, 16'h4000, 16'h1000, 1'b0, 1'b0};
    vecs[1]  = '{16'hD000, 16'h1000, 16'hA000, 1'b0, 1'b0};
    vecs[2]  = '{16'h8000, 16'h2000, 16'h8000, 1'b0, 1'b0};
    vecs[3]  = '{16'h2000, 16'hE000, 16'hE000, 1'b0, 1'b0};
    vecs[4]  = '{16'h2000, 16'h6000, 16'h0AAA, 1'b0, 1'b0};
    vecs[5]  = '{16'hE000, 16'h6000, 16'hF556, 1'b0, 1'b0};
    vecs[6]  = '{16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{16'h6000, 16'h1000, 16'h7FFF, 1'b1, 1'b0};
    vecs[8]  = '{16'hA000, 16'h1000, 16'h8000, 1'b1, 1'b0};
    vecs[9]  = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[10] = '{16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
    vecs[11] = '{16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[12] = '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].s, vecs[i].d, 0, 1'b0);

    // Backpressure: result held 5 cycles while in_valid toggles.
    run_op(16'h2000, 16'h6000, 16'h0AAA, 1'b0, 1'b0, 5, 1'b1);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    a = 16'h2000;
    b = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out", 32'(out), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h2000, 16'h4000, 16'h1000, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'($urandom);
        1: rb = 16'($urandom_range(1, 16'h0400));
        2: rb = 16'(-int'($urandom_range(1, 16'h0400)));
        default: rb = (i % 8 == 3) ? 16'h0000 : 16'($urandom_range(16'h1000, 16'h7FFF));
      endcase
      model(ra, rb, mo, ms, md);
      run_op(ra, rb, mo, ms, md, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
